// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler and compare interrupt.
// Latency: hit/rdata combinational; register writes land at the next edge; timer_interrupt lags its condition by 1 cycle.
// Backpressure: none; every load/store strobe is accepted in the cycle it is presented.
// Build option: define MTIME_SNAPSHOT_EN for tear-free 64-bit mtime reads (MTIME_HI returns a shadow latched by a MTIME_LO read).
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int unsigned PRESC_W   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic        rd_en,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        timer_interrupt
);

   // Word index of each register inside the 32-byte decode window.
   localparam logic [2:0] IDX_MTIME_LO = 3'd0;
   localparam logic [2:0] IDX_MTIME_HI = 3'd1;
   localparam logic [2:0] IDX_CMP_LO   = 3'd2;
   localparam logic [2:0] IDX_CMP_HI   = 3'd3;
   localparam logic [2:0] IDX_CTRL     = 3'd4;
   localparam logic [2:0] IDX_PRESC    = 3'd5;

   // ------------------------------------------------------------------
   // Architectural state
   // ------------------------------------------------------------------
   logic [63:0]        mtime;
   logic [63:0]        mtimecmp;
   logic               cnt_en;
   logic               irq_en;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] presc_cnt;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   // The window is matched on addr[31:5], so BASE_ADDR is expected to be
   // 32-byte aligned; the low five bits of BASE_ADDR are not compared.
   logic [2:0] word_idx;
   logic       win_match;
   logic       aligned;
   logic       wr_hit;
   logic       rd_hit;

   assign word_idx  = addr[4:2];
   assign win_match = (addr[31:5] == BASE_ADDR[31:5]);
   assign aligned   = (addr[1:0] == 2'b00);
   // Word slots 6 and 7 of the window are holes: not decoded, read as 0.
   assign hit       = win_match && aligned && (word_idx <= IDX_PRESC);
   assign wr_hit    = wr_en && hit;
   assign rd_hit    = rd_en && hit;

   // Per-register write strobes.
   logic we_mtime_lo;
   logic we_mtime_hi;
   logic we_cmp_lo;
   logic we_cmp_hi;
   logic we_ctrl;
   logic we_presc;

   assign we_mtime_lo = wr_hit && (word_idx == IDX_MTIME_LO);
   assign we_mtime_hi = wr_hit && (word_idx == IDX_MTIME_HI);
   assign we_cmp_lo   = wr_hit && (word_idx == IDX_CMP_LO);
   assign we_cmp_hi   = wr_hit && (word_idx == IDX_CMP_HI);
   assign we_ctrl     = wr_hit && (word_idx == IDX_CTRL);
   assign we_presc    = wr_hit && (word_idx == IDX_PRESC);

   // ------------------------------------------------------------------
   // Prescaler
   // ------------------------------------------------------------------
   // tick marks the cycle in which mtime advances: the prescale counter has
   // reached the programmed terminal value while counting is enabled.
   logic tick;
   assign tick = cnt_en && (presc_cnt == presc);

   // Prescale counter: restarts on a PRESC write, wraps at the terminal value, holds while disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_cnt <= '0;
      end else if (we_presc) begin
         presc_cnt <= '0;
      end else if (cnt_en) begin
         if (tick) begin
            presc_cnt <= '0;
         end else begin
            presc_cnt <= presc_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // mtime
   // ------------------------------------------------------------------
   // mtime: a software write to either half wins and drops that cycle's increment entirely
   // (no carry into the untouched half); otherwise advance on tick, wrapping silently at 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime <= '0;
      end else if (we_mtime_lo) begin
         mtime <= {mtime[63:32], wdata};
      end else if (we_mtime_hi) begin
         mtime <= {wdata, mtime[31:0]};
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   // ------------------------------------------------------------------
   // mtimecmp
   // ------------------------------------------------------------------
   // mtimecmp: each half is written independently; ordering of the two halves is left to software.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtimecmp <= '1;
      end else if (we_cmp_lo) begin
         mtimecmp <= {mtimecmp[63:32], wdata};
      end else if (we_cmp_hi) begin
         mtimecmp <= {wdata, mtimecmp[31:0]};
      end
   end

   // ------------------------------------------------------------------
   // Control and prescale registers
   // ------------------------------------------------------------------
   // CTRL: bit 0 enables counting, bit 1 enables the interrupt; upper write bits are discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_en <= 1'b0;
         irq_en <= 1'b0;
      end else if (we_ctrl) begin
         cnt_en <= wdata[0];
         irq_en <= wdata[1];
      end
   end

   // PRESC: only the low PRESC_W bits are stored.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (we_presc) begin
         presc <= wdata[PRESC_W-1:0];
      end
   end

   // ------------------------------------------------------------------
   // Interrupt
   // ------------------------------------------------------------------
   // Level interrupt registered from the pre-edge compare, so it trails the condition by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_interrupt <= 1'b0;
      end else begin
         timer_interrupt <= irq_en && (mtime >= mtimecmp);
      end
   end

   // ------------------------------------------------------------------
   // MTIME_HI read view
   // ------------------------------------------------------------------
   logic [31:0] mtime_hi_view;

`ifdef MTIME_SNAPSHOT_EN
   logic [31:0] hi_shadow;

   // Shadow of mtime[63:32]: captured by a MTIME_LO read so a following MTIME_HI read
   // belongs to the same 64-bit sample; a MTIME_HI write keeps it coherent.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_shadow <= '0;
      end else if (we_mtime_hi) begin
         hi_shadow <= wdata;
      end else if (rd_hit && (word_idx == IDX_MTIME_LO)) begin
         hi_shadow <= mtime[63:32];
      end
   end

   assign mtime_hi_view = hi_shadow;
`else
   assign mtime_hi_view = mtime[63:32];
`endif

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   logic [31:0] rd_mux;

   // Register read mux on current (pre-edge) values; a same-cycle write is not forwarded.
   always_comb begin
      rd_mux = '0;
      case (word_idx)
         IDX_MTIME_LO: rd_mux = mtime[31:0];
         IDX_MTIME_HI: rd_mux = mtime_hi_view;
         IDX_CMP_LO:   rd_mux = mtimecmp[31:0];
         IDX_CMP_HI:   rd_mux = mtimecmp[63:32];
         IDX_CTRL:     rd_mux = {30'd0, irq_en, cnt_en};
         IDX_PRESC:    rd_mux[PRESC_W-1:0] = presc;
         default:      rd_mux = '0;
      endcase
   end

   // Bus is quiet (all zeros) unless a load hits the window.
   assign rdata = rd_hit ? rd_mux : 32'd0;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard bench for mmio_timer with a behavioural model of the register map.
// Driver pushes expected hit/rdata per access; a negedge monitor pops and compares, and
// also compares timer_interrupt against the model every cycle out of reset.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'h0000_0400;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic [31:0] addr  = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic        hit;
   logic [31:0] rdata;
   logic        timer_interrupt;

   int checks   = 0;
   int failures = 0;
   int acc_id   = 0;

   mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .addr            (addr),
      .wdata           (wdata),
      .wr_en           (wr_en),
      .rd_en           (rd_en),
      .hit             (hit),
      .rdata           (rdata),
      .timer_interrupt (timer_interrupt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [63:0] m_mtime;
   logic [63:0] m_cmp;
   logic        m_cnt_en;
   logic        m_irq_en;
   logic        m_irq;
   logic [15:0] m_presc;
   int          m_phase;     // enabled cycles elapsed in the current prescale period
`ifdef MTIME_SNAPSHOT_EN
   logic [31:0] m_shadow;
`endif

   function automatic bit m_hit(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'h18) && ((a % 4) == 0);
   endfunction

   function automatic int m_reg(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!m_hit(a)) return 32'd0;
      case (m_reg(a))
         0: return m_mtime[31:0];
`ifdef MTIME_SNAPSHOT_EN
         1: return m_shadow;
`else
         1: return m_mtime[63:32];
`endif
         2: return m_cmp[31:0];
         3: return m_cmp[63:32];
         4: return {30'd0, m_irq_en, m_cnt_en};
         default: return {16'd0, m_presc};
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs presented before the edge.
   task automatic model_step();
      bit   advance;
      logic nirq;
      int   r;
      if (rst) begin
         m_mtime = 64'd0; m_cmp = '1; m_cnt_en = 0; m_irq_en = 0;
         m_irq = 0; m_presc = 0; m_phase = 0;
`ifdef MTIME_SNAPSHOT_EN
         m_shadow = 0;
`endif
         return;
      end
      nirq    = m_irq_en && (m_mtime >= m_cmp);
      advance = 0;
      if (m_cnt_en) begin
         if (m_phase == int'(m_presc)) begin advance = 1; m_phase = 0; end
         else m_phase = m_phase + 1;
      end
      r = (wr_en && m_hit(addr)) ? m_reg(addr) : -1;
`ifdef MTIME_SNAPSHOT_EN
      if (rd_en && m_hit(addr) && m_reg(addr) == 0) m_shadow = m_mtime[63:32];
      if (r == 1) m_shadow = wdata;
`endif
      case (r)
         0: m_mtime = {m_mtime[63:32], wdata};
         1: m_mtime = {wdata, m_mtime[31:0]};
         default: if (advance) m_mtime = m_mtime + 1;
      endcase
      if (r == 2) m_cmp = {m_cmp[63:32], wdata};
      if (r == 3) m_cmp = {wdata, m_cmp[31:0]};
      if (r == 4) begin m_cnt_en = wdata[0]; m_irq_en = wdata[1]; end
      if (r == 5) begin m_presc = wdata[15:0]; m_phase = 0; end
      m_irq = nirq;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          id;
      logic        hit;
      logic        chk_rd;
      logic [31:0] rdata;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         if (rd_en || wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_empty: got access at addr %h expected none", addr);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("hit#%0d@%h", e.id, addr), {31'd0, hit}, {31'd0, e.hit});
               if (e.chk_rd)
                  check($sformatf("rdata#%0d@%h", e.id, addr), rdata, e.rdata);
            end
         end
         check("timer_interrupt", {31'd0, timer_interrupt}, {31'd0, m_irq});
      end
   end

   // ---------------- driver ----------------
   task automatic access(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic use_c, input logic [31:0] cval);
      exp_t e;
      addr = a; wdata = d; wr_en = w; rd_en = r;
      if (w || r) begin
         acc_id++;
         e.id     = acc_id;
         e.hit    = m_hit(a);
         e.chk_rd = r;
         e.rdata  = use_c ? cval : model_read(a);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      access(1'b1, 1'b0, BASE + off, d, 1'b0, 32'd0);
   endtask

   task automatic rdm(input logic [31:0] off);
      access(1'b0, 1'b1, BASE + off, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic rdc(input logic [31:0] off, input logic [31:0] c);
      access(1'b0, 1'b1, BASE + off, 32'd0, 1'b1, c);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) access(1'b0, 1'b0, addr, 32'd0, 1'b0, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state, idle with counting off.
      idle(10);
      rdc(32'h00, 32'd0);
      rdc(32'h04, 32'd0);
      rdc(32'h08, 32'hFFFF_FFFF);
      rdc(32'h0C, 32'hFFFF_FFFF);
      rdc(32'h10, 32'd0);
      rdc(32'h14, 32'd0);

      // Prescale by 4: 40 enabled edges give exactly 10 counts.
      wr(32'h14, 32'd3);
      wr(32'h10, 32'd1);
      idle(40);
      rdc(32'h00, 32'd10);
      repeat (6) rdm(32'h00);

      // Carry from LO into HI with a single increment.
      wr(32'h10, 32'd0);
      wr(32'h14, 32'd0);
      wr(32'h04, 32'd0);
      wr(32'h00, 32'hFFFF_FFFF);
      wr(32'h10, 32'd1);
      wr(32'h10, 32'd0);
      rdc(32'h00, 32'd0);
      rdc(32'h04, 32'd1);

      // 64-bit wrap to zero.
      wr(32'h04, 32'hFFFF_FFFF);
      wr(32'h00, 32'hFFFF_FFFF);
      wr(32'h10, 32'd1);
      wr(32'h10, 32'd0);
      rdc(32'h00, 32'd0);
      rdc(32'h04, 32'd0);

      // Interrupt rises one cycle after mtime reaches 20, falls one cycle after CMP_LO=100.
      wr(32'h04, 32'd0);
      wr(32'h00, 32'd0);
      wr(32'h0C, 32'd0);
      wr(32'h08, 32'd20);
      wr(32'h10, 32'd3);
      idle(20);
      check("irq_at_match_cycle", {31'd0, timer_interrupt}, 32'd0);
      rdc(32'h00, 32'd20);
      check("irq_one_after_match", {31'd0, timer_interrupt}, 32'd1);
      wr(32'h08, 32'd100);
      check("irq_at_cmp_write_edge", {31'd0, timer_interrupt}, 32'd1);
      idle(1);
      check("irq_after_cmp_write", {31'd0, timer_interrupt}, 32'd0);

      // Software write beats the same-cycle increment.
      wr(32'h00, 32'h50);
      rdc(32'h00, 32'h50);
      rdm(32'h00);

      // Tear-free (or live) MTIME_HI read across a LO->HI carry.
      wr(32'h10, 32'd0);
      wr(32'h04, 32'd1);
      wr(32'h00, 32'hFFFF_FFFF);
      wr(32'h10, 32'd1);
      rdc(32'h00, 32'hFFFF_FFFF);
`ifdef MTIME_SNAPSHOT_EN
      rdc(32'h04, 32'd1);
`else
      rdc(32'h04, 32'd2);
`endif

      // Misaligned and hole addresses: no hit, read 0, writes ignored.
      access(1'b0, 1'b1, BASE + 32'h2, 32'd0, 1'b1, 32'd0);
      access(1'b0, 1'b1, BASE + 32'h18, 32'd0, 1'b1, 32'd0);
      access(1'b1, 1'b0, BASE + 32'h1, 32'h1234_5678, 1'b0, 32'd0);
      access(1'b1, 1'b0, BASE + 32'h1C, 32'h1234_5678, 1'b0, 32'd0);
      rdm(32'h00);
      rdm(32'h04);
      // Read and write together: old value returned.
      access(1'b1, 1'b1, BASE + 32'h08, 32'h0000_0777, 1'b0, 32'd0);
      rdc(32'h08, 32'h0000_0777);

      // Reset mid-operation with a pending store.
      wr(32'h14, 32'd0);
      addr = BASE; wdata = 32'hDEAD_BEEF; wr_en = 1'b1; rst = 1'b1;
      @(posedge clk);
      #1 wr_en = 1'b0; rst = 1'b0;
      rdc(32'h00, 32'd0);
      rdc(32'h08, 32'hFFFF_FFFF);
      rdc(32'h10, 32'd0);
      check("irq_after_reset", {31'd0, timer_interrupt}, 32'd0);

      // Randomised traffic against the model.
      for (int i = 0; i < 500; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         int          sel;
         int          op;
         sel = $urandom_range(0, 11);
         if (sel < 8)
            a = BASE + 32'(sel) * 4;
         else if (sel < 10)
            a = BASE + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(1, 3));
         else
            a = ($urandom_range(0, 1) == 1) ? BASE + 32'h40 : BASE - 32'd4;
         d = $urandom;
         if (m_hit(a)) begin
            case (m_reg(a))
               0, 2: if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 80));
               1, 3: if ($urandom_range(0, 3) != 0) d = 32'd0;
               5:    d = 32'($urandom_range(0, 3));
               default: ;
            endcase
         end
         op = $urandom_range(0, 9);
         if (op < 4)       access(1'b1, 1'b0, a, d, 1'b0, 32'd0);
         else if (op < 8)  access(1'b0, 1'b1, a, 32'd0, 1'b0, 32'd0);
         else if (op == 8) access(1'b1, 1'b1, a, d, 1'b0, 32'd0);
         else              access(1'b0, 1'b0, a, 32'd0, 1'b0, 32'd0);
      end

      // PRESC keeps only its low 16 bits.
      wr(32'h14, 32'hFFFF_0002);
      rdc(32'h14, 32'd2);

      idle(3);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
